// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: machine word and the writeback buffer entry
// used by the register-file write-side front end.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t rd;
    word_t    data;
  } wb_entry_t;

endpackage

// File: rtl/rv32i_wb_rr_arbiter.sv
// Round-robin arbiter for the writeback buffers: one grant per cycle,
// search begins one past the last granted source.
module rv32i_wb_rr_arbiter #(
  parameter int NUM_SRC = 3,
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_SRC-1:0] req,
  input  logic               take,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] last_grant;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value held and infer a latch.
  always_comb begin
    logic found;
    int   s;
    gnt     = '0;
    gnt_idx = last_grant;
    found   = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      s = int'(last_grant) + k;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (!found && req[s]) begin
        found   = 1'b1;
        gnt[s]  = 1'b1;
        gnt_idx = IDX_W'(s);
      end
    end
  end

  // Reset points at the last source so source 0 is searched first.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     last_grant <= IDX_W'(NUM_SRC - 1);
    else if (take) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/rv32i_rf_writeback.sv
// Register-file write-side front end: one-entry buffer per result source,
// round-robin onto the single write port. `RF_WB_FWD_EN adds decode forwarding.
module rv32i_rf_writeback
  import rv32i_types_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC-1:0][REG_W-1:0] src_rd,
  input  word_t [NUM_SRC-1:0]           src_data,
  output logic                          wen,
  output logic [REG_W-1:0]              rd,
  output word_t                         w_data,
  output logic [NUM_SRC-1:0]            busy
`ifdef RF_WB_FWD_EN
  ,
  input  logic [REG_W-1:0]              fwd_rs1,
  input  logic [REG_W-1:0]              fwd_rs2,
  output logic                          fwd_rs1_hit,
  output word_t                         fwd_rs1_data,
  output logic                          fwd_rs2_hit,
  output word_t                         fwd_rs2_data
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  wb_entry_t          buf_q [NUM_SRC];
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               take;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i]       = buf_q[i].valid;
      src_ready[i] = !buf_q[i].valid || gnt[i];
    end
  end

  assign busy = req;
  assign take = |gnt;

  rv32i_wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .CLK     (CLK),
    .nRST    (nRST),
    .req     (req),
    .take    (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A result for x0 is consumed but never marked valid, so it is dropped.
  // NOTE: the small buffers are fully reset so an entry never carries stale rd/data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SRC; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          buf_q[i].valid <= (src_rd[i] != '0);
          buf_q[i].rd    <= src_rd[i];
          buf_q[i].data  <= src_data[i];
        end else if (gnt[i]) begin
          buf_q[i].valid <= 1'b0;
        end
      end
    end
  end

  // rd/w_data hold their last written values when no grant occurs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wen    <= 1'b0;
      rd     <= '0;
      w_data <= '0;
    end else begin
      wen <= take;
      if (take) begin
        rd     <= buf_q[gnt_idx].rd;
        w_data <= buf_q[gnt_idx].data;
      end
    end
  end

`ifdef RF_WB_FWD_EN
  assign fwd_rs1_hit  = wen && (rd == fwd_rs1) && (fwd_rs1 != '0);
  assign fwd_rs1_data = w_data;
  assign fwd_rs2_hit  = wen && (rd == fwd_rs2) && (fwd_rs2 != '0);
  assign fwd_rs2_data = w_data;
`endif

endmodule

// File: tb/tb_rv32i_rf_writeback.sv
// Scoreboard bench for rv32i_rf_writeback: directed scenarios plus random
// traffic, checked cycle by cycle against a behavioural model.
module tb_rv32i_rf_writeback;

  localparam int NUM_SRC = 3;

  logic                      CLK = 1'b0;
  logic                      nRST = 1'b0;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC-1:0][4:0]   src_rd = '0;
  logic [NUM_SRC-1:0][31:0]  src_data = '0;
  logic                      wen;
  logic [4:0]                rd;
  logic [31:0]               w_data;
  logic [NUM_SRC-1:0]        busy;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif

  always #5 CLK = ~CLK;

  rv32i_rf_writeback #(.NUM_SRC(NUM_SRC)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .wen       (wen),
    .rd        (rd),
    .w_data    (w_data),
    .busy      (busy)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs2_data (fwd_rs2_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: pending result per source, last winner, write-port image.
  bit        m_v    [NUM_SRC];
  bit [4:0]  m_rd   [NUM_SRC];
  bit [31:0] m_data [NUM_SRC];
  int        m_last = NUM_SRC - 1;
  bit        m_out_wen  = 1'b0;
  bit [4:0]  m_out_rd   = '0;
  bit [31:0] m_out_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NUM_SRC; k++) begin
      int s;
      s = (m_last + k) % NUM_SRC;
      if (m_v[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_step();
    int   g;
    bit   was_v [NUM_SRC];
    exp_t e;
    if (!nRST) begin
      for (int i = 0; i < NUM_SRC; i++) m_v[i] = 1'b0;
      m_last = NUM_SRC - 1;
      m_out_wen = 1'b0; m_out_rd = '0; m_out_data = '0;
      exp_q.delete();
      return;
    end
    g = model_grant();
    for (int i = 0; i < NUM_SRC; i++) was_v[i] = m_v[i];
    if (g >= 0) begin
      m_out_wen  = 1'b1;
      m_out_rd   = m_rd[g];
      m_out_data = m_data[g];
      m_last     = g;
      m_v[g]     = 1'b0;
    end else begin
      m_out_wen = 1'b0;
    end
    e.wen = m_out_wen; e.rd = m_out_rd; e.data = m_out_data;
    exp_q.push_back(e);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && (!was_v[i] || i == g)) begin
        m_v[i]    = (src_rd[i] != 5'd0);
        m_rd[i]   = src_rd[i];
        m_data[i] = src_data[i];
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge nRST);
    model_step();
  end

  // Monitor: one expected write-port image per clock, plus buffer status.
  task automatic monitor_step();
    exp_t e;
    int   g;
    logic [NUM_SRC-1:0] eb, er;
    g = model_grant();
    for (int i = 0; i < NUM_SRC; i++) begin
      eb[i] = m_v[i];
      er[i] = !m_v[i] || (i == g);
    end
    check("busy", 32'(busy), 32'(eb));
    check("src_ready", 32'(src_ready), 32'(er));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.wen = 1'b0; e.rd = m_out_rd; e.data = m_out_data;
    end
    check("wen", 32'(wen), 32'(e.wen));
    check("rd", 32'(rd), 32'(e.rd));
    check("w_data", w_data, e.data);
  endtask

  initial forever begin
    @(negedge CLK);
    monitor_step();
  end

  task automatic next();
    @(negedge CLK);
    #2;
    src_valid = '0;
`ifdef RF_WB_FWD_EN
    fwd_rs1 = ($urandom_range(1, 0) != 0) ? m_out_rd : 5'($urandom_range(31, 0));
    fwd_rs2 = ($urandom_range(3, 0) == 0) ? 5'd0 : m_out_rd;
    #1;
    check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(m_out_wen && fwd_rs1 == m_out_rd && fwd_rs1 != 0));
    check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(m_out_wen && fwd_rs2 == m_out_rd && fwd_rs2 != 0));
    if (m_out_wen) check("fwd_rs1_data", fwd_rs1_data, m_out_data);
`endif
  endtask

  task automatic put(input int i, input logic [4:0] r, input logic [31:0] d);
    src_valid[i] = 1'b1;
    src_rd[i]    = r;
    src_data[i]  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic random_traffic(input int n);
    repeat (n) begin
      next();
      for (int i = 0; i < NUM_SRC; i++)
        if ($urandom_range(1, 0) != 0)
          put(i, 5'($urandom_range(31, 0)), $urandom());
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;
    idle(2);

    // Single source.
    next(); put(1, 5'd5, 32'hDEADBEEF);
    idle(4);

    // Contention, then a second burst to confirm the rotation restarts at 0.
    next(); put(0, 5'd1, 32'h11); put(1, 5'd2, 32'h22); put(2, 5'd3, 32'h33);
    idle(5);
    next(); put(0, 5'd4, 32'h44); put(1, 5'd5, 32'h55); put(2, 5'd6, 32'h66);
    idle(5);

    // Result for x0 is swallowed.
    next(); put(0, 5'd0, 32'hFFFFFFFF);
    idle(3);

    // Back-to-back from one source.
    for (int r = 7; r <= 10; r++) begin
      next(); put(0, 5'(r), 32'h1000 + 32'(r));
    end
    idle(6);

    random_traffic(300);

    // Reset while buffers are full.
    next(); put(0, 5'd12, 32'hA); put(1, 5'd13, 32'hB); put(2, 5'd14, 32'hC);
    next(); put(0, 5'd15, 32'hD); put(1, 5'd16, 32'hE); put(2, 5'd17, 32'hF);
    @(negedge CLK);
    #2;
    src_valid = '0;
    nRST = 1'b0;
    #1;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'(3'b111));
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;
    idle(4);

    random_traffic(200);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_rf_writeback.md
# rv32i_rf_writeback

Write-side front end of the integer register file: collects completed results from up to NUM_SRC functional units (ALU, load unit, multi-cycle mul/div), buffers one result per source, and round-robin arbitrates them onto the register file's single write port (wen/rd/w_data). It sits between the execute/memory stages and the register file. It lets long-latency units retire out of step with the main pipeline without stalling one another.

## Interface
- NUM_SRC, 3, number of result sources (2..8)
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  asynchronous, active-low reset
- src_valid  input  NUM_SRC  source i has a result this cycle
- src_ready  output  NUM_SRC  block can accept source i this cycle
- src_rd  input  NUM_SRC x 5  destination register per source
- src_data  input  NUM_SRC x 32  result word per source (word_t)
- wen  output  1  register file write enable (registered)
- rd  output  5  register file write address (registered)
- w_data  output  32  register file write data (registered)
- busy  output  NUM_SRC  buffer i holds an unissued result

## Operation
- Per source: one-entry buffer (valid bit, rd, data). A transfer occurs when src_valid[i] && src_ready[i] at a rising edge.
- src_ready[i] = buffer i empty OR buffer i granted this cycle. This allows back-to-back transfers from one source at one per cycle.
- A result with src_rd == 0 is accepted, then discarded. The buffer stays empty and nothing is issued.
- Arbiter: among full buffers, grants exactly one per cycle, round-robin. The search starts at (last_grant + 1) mod NUM_SRC. last_grant updates only when a grant occurs.
- The granted entry loads the output register at the next edge: wen=1, rd, w_data. If there is no grant, wen=0 at the next edge. rd and w_data hold their previous values.
- busy[i] mirrors buffer i's valid bit.
- Precondition (pipeline responsibility, not checked): no two outstanding results target the same nonzero rd.

## Timing
- Reset (async, nRST low): all buffers empty, last_grant = NUM_SRC-1 (so source 0 wins first), wen=0, rd=0, w_data=0, busy=0, src_ready all 1.
- Latency: accepted at edge E0 → granted in cycle after E0 → wen/rd/w_data valid after E1 → register file updates at E2.
- Throughput: one write per cycle sustained when any buffer is full.
- Simultaneous events:
  - If all NUM_SRC sources transfer at the same edge, they drain over NUM_SRC consecutive cycles in round-robin order.
  - Same-edge grant and refill of one buffer is legal. The new entry is eligible in the following cycle.
- Reset mid-operation: buffered results are lost and the output register is cleared immediately; no partial write is issued.

## Configuration
- RF_WB_FWD_EN defined: adds inputs fwd_rs1 and fwd_rs2 (5 bits each), and outputs fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data.
  - Combinational compare against the output register: hit = wen && rd == fwd_rsX && fwd_rsX != 0; data = w_data.
  - This lets decode read a value in the cycle before the register file commits it.
- Undefined: these ports and their logic are absent. Write behaviour is identical in both builds.

## Structure
- rv32i_types_pkg: word_t (existing), and new wb_entry_t struct {logic valid; logic [4:0] rd; word_t data;}.
- One sub-module: rv32i_wb_rr_arbiter, parameterised by NUM_SRC.
  - Inputs: request vector, grant-taken strobe.
  - Outputs: one-hot grant and grant index.
  - Owns the last_grant register; async reset to NUM_SRC-1.
- Top: buffers, ready logic, x0 drop, output register, optional forwarding.

## Test plan
- Reset: hold nRST low mid-stream with buffers full → wen=0, rd=0, w_data=0, busy=0, src_ready=all 1 within the reset cycle; no write after release.
- Single source: src 1 sends rd=5, data=0xDEADBEEF at E0 → wen=1, rd=5, w_data=0xDEADBEEF after E1, exactly one cycle; busy[1] high only between E0 and E1.
- Contention: sources 0, 1, 2 all send at E0 (rd=1/2/3, data=0x11/0x22/0x33) → writes rd=1, 2, 3 on three consecutive cycles; a second burst then starts with source 0 only if last grant was 2.
- x0 drop: src 0 sends rd=0, data=0xFFFFFFFF → src_ready stays 1, busy[0] stays 0, wen never asserts.
- Back-to-back: src 0 valid for 4 cycles with rd=7..10 while others idle → 4 consecutive writes rd=7, 8, 9, 10; src_ready[0] never drops.
- Forwarding (RF_WB_FWD_EN): fwd_rs1=7 while output holds wen=1, rd=7, 0x1234 → fwd_rs1_hit=1, fwd_rs1_data=0x1234; fwd_rs2=0 with rd=0 → hit=0.
